pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage core. It merges stall requests from decode and the multi-cycle execute sequencer into the per-stage `stall` vector, which drives every pipeline register including `ex_mem`. It also issues a one-cycle flush with a redirect PC on an exception from the memory stage. A multi-cycle execute operation, such as `madd`/`msub` or divide, is tracked by an internal FSM and counter, so EX holds its instruction for exactly N cycles.

## Interface

Parameters:
- `CNT_W`, default 6: width of the multi-cycle length and counter. Maximum operation length is 2^CNT_W−1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- `stallreq_from_id`  in  1  decode hazard (load-use) stall request.
- `ex_mc_start`  in  1  EX holds a multi-cycle op this cycle; sampled only in IDLE.
- `ex_mc_cycles`  in  CNT_W  total EX occupancy N of that op, in cycles.
- `flush_req`  in  1  exception detected in MEM.
- `new_pc_in`  in  32  exception handler address accompanying `flush_req`.
- `stall`  out  6  bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB. Combinational.
- `flush`  out  1  clear IF/ID, ID/EX, EX/MEM, MEM/WB this cycle. Combinational.
- `new_pc`  out  32  redirect PC. Equals `new_pc_in` when `flush`=1, else 0.
- `ex_mc_busy`  out  1  FSM is in BUSY or DONE.
- `ex_mc_done`  out  1  last EX cycle of a multi-cycle op; the result is valid.
- `ex_mc_count`  out  CNT_W  remaining BUSY cycles, registered.
- `stall_cycles`  out  32  saturating count of cycles with `stall[0]`=1.

## Operation

- FSM states: IDLE, BUSY, DONE. Counter `cnt` is CNT_W bits. `ex_mc_count` equals `cnt`.
- Transitions from IDLE, when `ex_mc_start`=1 and `flush_req`=0:
  - N≤1: no action; the op is treated as single-cycle.
  - N=2: go to DONE.
  - N≥3: go to BUSY with `cnt` ← N−2.
- BUSY: `cnt` decrements each cycle. When `cnt`=1, go to DONE with `cnt` ← 0.
- DONE: lasts one cycle, then IDLE.
- `ex_mc_start` is ignored in BUSY and DONE.
- EX stall request `ex_stall` is 1 in any of:
  - IDLE with an accepted start (N≥2);
  - BUSY.
- `ex_stall` is 0 in DONE.
- Stall vector, in priority order:
  - `rst` or `flush_req` → 6'b000000;
  - `ex_stall` → 6'b001111;
  - `stallreq_from_id` → 6'b000111;
  - otherwise 6'b000000.
- Downstream rule: a register with `stall[n]`=1 and `stall[n+1]`=0 inserts a bubble.
- `ex_mc_done` = 1 in DONE, 0 otherwise.
- `ex_mc_busy` = 1 in BUSY or DONE.
- Flush:
  - `flush_req`=1 and `rst`=0 → `flush`=1 and `new_pc`=`new_pc_in` in the same cycle.
  - At the next edge the FSM goes to IDLE and `cnt` ← 0, cancelling any in-flight op.
  - A start arriving in the same cycle as `flush_req` is dropped.
  - `ex_mc_done` still reflects the current state during the flush cycle.
- `stall_cycles`: increments by 1 at each edge where `stall[0]`=1. Holds at 32'hFFFFFFFF.

## Timing

- Reset:
  - While `rst`=1, all combinational outputs are 0.
  - At the edge: state ← IDLE, `cnt` ← 0, `stall_cycles` ← 0.
  - `rst` overrides `flush_req` and `ex_mc_start`.
  - Reset in BUSY aborts the op; the cycle after reset is IDLE with `ex_mc_busy`=0.
- Multi-cycle op accepted at cycle t with length N≥2:
  - `stall`=6'b001111 in cycles t … t+N−2;
  - `ex_mc_done`=1 in cycle t+N−1, with `stall` from EX released;
  - IDLE again at t+N.
- In BUSY, `ex_mc_count` reads N−2 at t+1 and decrements to 1 at t+N−2.
- `stallreq_from_id` together with BUSY: output is 001111. ID is stalled either way.
- After DONE, a new op can be accepted in the following cycle (t+N), giving back-to-back ops with no gap.
- Zero-cycle latency from `flush_req`/`stallreq_from_id` to outputs.
- No output depends combinationally on `ex_mc_cycles` except `stall` in the accept cycle.

## Test plan

- Reset then idle. Hold `rst`=1 for 2 cycles, then 5 idle cycles → `stall`=0, `flush`=0, `ex_mc_busy`=0, `stall_cycles`=0.
- ID stall. `stallreq_from_id`=1 for 3 cycles → `stall`=6'b000111 for exactly those cycles; `stall_cycles`=3 afterwards.
- Multi-cycle op. `ex_mc_start` with N=5 at cycle t:
  - `stall`=6'b001111 at t…t+3;
  - `ex_mc_count` = 3, 2, 1 at t+1…t+3;
  - `ex_mc_done`=1 only at t+4;
  - `stall_cycles`=4.
- Short ops:
  - N=1 → no stall, no busy.
  - N=2 → `stall` at t only, `ex_mc_done` at t+1.
  - Back-to-back start at t+2 of a second N=2 op → `stall` at t+2, done at t+3.
- Flush mid-op. N=10 started at t, `flush_req`=1 at t+4 with `new_pc_in`=32'h0000_0020:
  - at t+4: `flush`=1, `new_pc`=32'h20, `stall`=0;
  - at t+5: IDLE, `ex_mc_busy`=0, `ex_mc_count`=0, and `ex_mc_done` never asserted.
- Reset mid-op and saturation:
  - `rst` at t+3 of an N=8 op → IDLE next cycle with all outputs 0.
  - Force `stall_cycles` near 32'hFFFFFFFE and stall 3 cycles → holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Pipeline control unit for the five-stage core. It merges the decode hazard
// stall and the multi-cycle execute sequencer into one per-stage stall vector.
// It also raises a single-cycle flush with a redirect PC when MEM reports an
// exception.
//
// Multi-cycle EX operations (madd/msub, divide, ...) are tracked by a small
// FSM (IDLE -> BUSY -> DONE) and a down-counter. EX holds its instruction for
// exactly N cycles: it stalls for N-1 cycles, and the result is valid in the
// last (DONE) cycle.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   stallreq_from_id  load-use hazard stall request from decode
//   ex_mc_start       EX holds a multi-cycle op (sampled only in IDLE)
//   ex_mc_cycles      total EX occupancy N of that op
//   flush_req         exception detected in MEM
//   new_pc_in         exception handler address
//   stall[5:0]        per-stage stall {WB,MEM,EX,ID,IF,PC} (combinational)
//   flush             clear all pipeline registers this cycle (combinational)
//   new_pc            redirect PC, 0 unless flush
//   ex_mc_busy        FSM in BUSY or DONE
//   ex_mc_done        last EX cycle of a multi-cycle op
//   ex_mc_count       remaining BUSY cycles (registered)
//   stall_cycles      saturating count of cycles with stall[0]=1
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_id,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_cycles,
    input  logic             flush_req,
    input  logic [31:0]      new_pc_in,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             ex_mc_busy,
    output logic             ex_mc_done,
    output logic [CNT_W-1:0] ex_mc_count,
    output logic [31:0]      stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Stalling PC..EX leaves MEM running, so EX/MEM receives a bubble.
    localparam logic [5:0] STALL_EX   = 6'b001111;
    // Stalling PC..ID leaves EX running, so ID/EX receives a bubble.
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_stall;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        ex_stall = 1'b0;

        unique case (state_q)
            IDLE: begin
                // N<=1 is a plain single-cycle op: nothing to track.
                if (ex_mc_start && !flush_req && ex_mc_cycles >= CNT_TWO) begin
                    ex_stall = 1'b1;
                    if (ex_mc_cycles == CNT_TWO) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        // The accept cycle and the DONE cycle are not counted.
                        state_d = BUSY;
                        cnt_d   = ex_mc_cycles - CNT_TWO;
                    end
                end
            end
            BUSY: begin
                ex_stall = 1'b1;
                if (cnt_q <= CNT_ONE) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // An exception cancels any in-flight op at the next edge.
        if (flush_req) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            stall_cycles <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall[0] && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        stall      = STALL_NONE;
        flush      = 1'b0;
        new_pc     = '0;
        ex_mc_busy = 1'b0;
        ex_mc_done = 1'b0;

        if (!rst) begin
            ex_mc_busy = (state_q == BUSY) || (state_q == DONE);
            ex_mc_done = (state_q == DONE);

            if (flush_req) begin
                flush  = 1'b1;
                new_pc = new_pc_in;
            end else if (ex_stall) begin
                stall = STALL_EX;
            end else if (stallreq_from_id) begin
                stall = STALL_ID;
            end
        end
    end

    assign ex_mc_count = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Directed-vector bench for pipe_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the falling edge. A "cycle" is the span
// between two rising edges. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_from_id;
    logic             ex_mc_start;
    logic [CNT_W-1:0] ex_mc_cycles;
    logic             flush_req;
    logic [31:0]      new_pc_in;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             ex_mc_busy;
    logic             ex_mc_done;
    logic [CNT_W-1:0] ex_mc_count;
    logic [31:0]      stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_from_id (stallreq_from_id),
        .ex_mc_start      (ex_mc_start),
        .ex_mc_cycles     (ex_mc_cycles),
        .flush_req        (flush_req),
        .new_pc_in        (new_pc_in),
        .stall            (stall),
        .flush            (flush),
        .new_pc           (new_pc),
        .ex_mc_busy       (ex_mc_busy),
        .ex_mc_done       (ex_mc_done),
        .ex_mc_count      (ex_mc_count),
        .stall_cycles     (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Move to the sampling point of the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    // Advance to the start of the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallreq_from_id = 1'b0;
        ex_mc_start      = 1'b0;
        ex_mc_cycles     = '0;
        flush_req        = 1'b0;
        new_pc_in        = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;

        // ---------------- reset, with all other requests asserted ------------
        stallreq_from_id = 1'b1;
        ex_mc_start      = 1'b1;
        ex_mc_cycles     = 6'd5;
        flush_req        = 1'b1;
        new_pc_in        = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("rst_stall", 32'(stall), 32'h00);
            check("rst_flush", 32'(flush), 32'h0);
            check("rst_new_pc", new_pc, 32'h0);
            check("rst_busy", 32'(ex_mc_busy), 32'h0);
            tick();
        end
        idle_inputs();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("idle_stall", 32'(stall), 32'h00);
            check("idle_flush", 32'(flush), 32'h0);
            check("idle_busy", 32'(ex_mc_busy), 32'h0);
            check("idle_count", 32'(ex_mc_count), 32'h0);
            check("idle_stall_cycles", stall_cycles, 32'd0);
            tick();
        end

        // ---------------- ID stall for 3 cycles --------------------------------
        stallreq_from_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("id_stall", 32'(stall), 32'h07);
            tick();
        end
        stallreq_from_id = 1'b0;
        sample();
        check("id_release", 32'(stall), 32'h00);
        check("id_stall_cycles", stall_cycles, 32'd3);
        tick();

        // ---------------- multi-cycle op, N=5 ----------------------------------
        do_reset();
        ex_mc_start  = 1'b1;
        ex_mc_cycles = 6'd5;
        sample();                                   // t
        check("mc5_t_stall", 32'(stall), 32'h0F);
        check("mc5_t_busy", 32'(ex_mc_busy), 32'h0);
        check("mc5_t_done", 32'(ex_mc_done), 32'h0);
        tick();
        ex_mc_start  = 1'b0;
        ex_mc_cycles = '0;
        for (int i = 1; i <= 3; i++) begin          // t+1 .. t+3
            stallreq_from_id = (i == 2);            // ID request overlapping BUSY
            sample();
            check("mc5_busy_stall", 32'(stall), 32'h0F);
            check("mc5_busy_count", 32'(ex_mc_count), 32'(4 - i));
            check("mc5_busy_busy", 32'(ex_mc_busy), 32'h1);
            check("mc5_busy_done", 32'(ex_mc_done), 32'h0);
            tick();
        end
        stallreq_from_id = 1'b0;
        sample();                                   // t+4
        check("mc5_done_stall", 32'(stall), 32'h00);
        check("mc5_done_done", 32'(ex_mc_done), 32'h1);
        check("mc5_done_busy", 32'(ex_mc_busy), 32'h1);
        check("mc5_done_count", 32'(ex_mc_count), 32'h0);
        tick();
        sample();                                   // t+5
        check("mc5_idle_done", 32'(ex_mc_done), 32'h0);
        check("mc5_idle_busy", 32'(ex_mc_busy), 32'h0);
        check("mc5_stall_cycles", stall_cycles, 32'd4);
        tick();

        // ---------------- short ops --------------------------------------------
        do_reset();
        ex_mc_start  = 1'b1;
        ex_mc_cycles = 6'd1;
        sample();
        check("n1_stall", 32'(stall), 32'h00);
        tick();
        ex_mc_start = 1'b0;
        sample();
        check("n1_busy", 32'(ex_mc_busy), 32'h0);
        tick();

        for (int k = 0; k < 2; k++) begin           // two back-to-back N=2 ops
            ex_mc_start  = 1'b1;
            ex_mc_cycles = 6'd2;
            sample();
            check("n2_accept_stall", 32'(stall), 32'h0F);
            check("n2_accept_done", 32'(ex_mc_done), 32'h0);
            check("n2_accept_busy", 32'(ex_mc_busy), 32'h0);
            tick();
            ex_mc_start = 1'b0;
            sample();
            check("n2_done_stall", 32'(stall), 32'h00);
            check("n2_done_done", 32'(ex_mc_done), 32'h1);
            check("n2_done_busy", 32'(ex_mc_busy), 32'h1);
            tick();
        end
        sample();
        check("n2_after_busy", 32'(ex_mc_busy), 32'h0);
        check("n2_stall_cycles", stall_cycles, 32'd2);
        tick();

        // ---------------- flush mid-op, N=10 ------------------------------------
        do_reset();
        ex_mc_start  = 1'b1;
        ex_mc_cycles = 6'd10;
        sample();
        check("fl_t_stall", 32'(stall), 32'h0F);
        tick();
        ex_mc_start = 1'b0;
        for (int i = 1; i <= 3; i++) begin          // t+1 .. t+3, cnt 8,7,6
            sample();
            check("fl_busy_count", 32'(ex_mc_count), 32'(9 - i));
            check("fl_busy_done", 32'(ex_mc_done), 32'h0);
            tick();
        end
        flush_req    = 1'b1;                        // t+4, with a start that is dropped
        new_pc_in    = 32'h0000_0020;
        ex_mc_start  = 1'b1;
        ex_mc_cycles = 6'd3;
        sample();
        check("fl_flush", 32'(flush), 32'h1);
        check("fl_new_pc", new_pc, 32'h0000_0020);
        check("fl_stall", 32'(stall), 32'h00);
        check("fl_count", 32'(ex_mc_count), 32'd5);
        check("fl_flush_done", 32'(ex_mc_done), 32'h0);
        tick();
        idle_inputs();
        sample();                                   // t+5
        check("fl_after_busy", 32'(ex_mc_busy), 32'h0);
        check("fl_after_count", 32'(ex_mc_count), 32'h0);
        check("fl_after_done", 32'(ex_mc_done), 32'h0);
        check("fl_after_flush", 32'(flush), 32'h0);
        check("fl_after_new_pc", new_pc, 32'h0);
        tick();

        // ---------------- reset mid-op, N=8 -------------------------------------
        do_reset();
        ex_mc_start  = 1'b1;
        ex_mc_cycles = 6'd8;
        tick();
        ex_mc_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;                                 // t+3
        sample();
        check("rm_rst_stall", 32'(stall), 32'h00);
        check("rm_rst_busy", 32'(ex_mc_busy), 32'h0);
        tick();
        rst = 1'b0;
        sample();                                   // t+4
        check("rm_after_busy", 32'(ex_mc_busy), 32'h0);
        check("rm_after_done", 32'(ex_mc_done), 32'h0);
        check("rm_after_count", 32'(ex_mc_count), 32'h0);
        check("rm_after_stall", 32'(stall), 32'h00);
        check("rm_after_stall_cycles", stall_cycles, 32'd0);
        tick();

        // ---------------- stall_cycles saturation -------------------------------
        sample();
        force dut.stall_cycles = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cycles;
        tick();
        sample();
        check("sat_preload", stall_cycles, 32'hFFFF_FFFD);
        tick();
        stallreq_from_id = 1'b1;
        tick();
        sample();
        check("sat_1", stall_cycles, 32'hFFFF_FFFE);
        tick();
        sample();
        check("sat_2", stall_cycles, 32'hFFFF_FFFF);
        tick();
        sample();
        check("sat_3", stall_cycles, 32'hFFFF_FFFF);
        tick();
        stallreq_from_id = 1'b0;
        tick();
        sample();
        check("sat_hold", stall_cycles, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
